// File: rtl/sha256_msg_feeder_if.sv
// Host-side message word handshake into sha256_msg_feeder.
//   start_in      : 1-cycle pulse that opens a new message
//   data_in       : big-endian message word (byte0 = [31:24])
//   valid_in      : data_in valid
//   last_in       : data_in is the final message word
//   last_bytes_in : valid bytes in the last word (00=4, 01=1, 10=2, 11=3)
//   ready_out     : feeder accepts data_in this cycle
interface sha256_msg_feeder_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  last_in;
    logic [1:0]            last_bytes_in;
    logic                  ready_out;

    modport master (
        output start_in, data_in, valid_in, last_in, last_bytes_in,
        input  ready_out
    );

    modport slave (
        input  start_in, data_in, valid_in, last_in, last_bytes_in,
        output ready_out
    );
endinterface

// File: rtl/sha256_msg_feeder.sv
// SHA-256 message feeder: accepts host words, applies padding (0x80, zeros,
// 64-bit bit length) and drives the phase/count/word bus into the expander
// (16 LOAD beats then 64 EXPAND beats per 512-bit block).
//   clk, rst_n      : clock, asynchronous active-low reset
//   host            : word handshake (slave side)
//   fsm_out         : 000 IDLE, 010 LOAD, 011 EXPAND
//   count_out       : word index 0..15 in LOAD, beat 0..63 in EXPAND
//   data_out        : word for count_out in LOAD, else 0
//   first_block_out : high through the first block of a message
//   block_done_out  : pulse after EXPAND beat 63 of every block
//   msg_done_out    : pulse after EXPAND beat 63 of the final block
module sha256_msg_feeder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sha256_msg_feeder_if.slave    host,
    output logic [2:0]            fsm_out,
    output logic [6:0]            count_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  first_block_out,
    output logic                  block_done_out,
    output logic                  msg_done_out
);
    localparam int unsigned DW = DATA_WIDTH;
    localparam logic [2:0]  PH_IDLE   = 3'b000;
    localparam logic [2:0]  PH_LOAD   = 3'b010;
    localparam logic [2:0]  PH_EXPAND = 3'b011;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD, S_EXPAND} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;        // next LOAD/PAD word index
    logic [6:0]             exp_q, exp_d;        // EXPAND beat counter, 64 = exit
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic                   marker_q, marker_d;  // 0x80 marker still to be emitted
    logic                   final_q, final_d;    // current block carries the length
    logic                   msg_end_q, msg_end_d;
    logic                   first_q, first_d;
    logic                   ready_q, ready_d;
    logic [2:0]             fsm_q, fsm_d;
    logic [6:0]             cnt_q, cnt_d;
    logic [DW-1:0]          data_q, data_d;
    logic                   bdone_q, bdone_d;
    logic                   mdone_q, mdone_d;

    logic                   accept;
    logic [DW-1:0]          last_word;
    logic [LEN_WIDTH-1:0]   len_add;
    logic [4:0]             marker_pos;
    logic [63:0]            len64;

    // Word generated during padding: marker first, length in words 14/15 of the final block.
    function automatic logic [31:0] pad_word(input logic [3:0] i, input logic mk,
                                             input logic fin, input logic [63:0] len);
        if (mk)                    return 32'h8000_0000;
        else if (fin && i == 4'd14) return len[63:32];
        else if (fin && i == 4'd15) return len[31:0];
        else                       return 32'h0;
    endfunction

    assign accept = host.valid_in & ready_q;
    assign len64  = 64'(len_q);

    // Final partial word: keep n valid bytes, place 0x80 in byte n.
    always_comb begin
        last_word = host.data_in;
        case (host.last_bytes_in)
            2'b01:   last_word = {host.data_in[31:24], 8'h80, 16'h0000};
            2'b10:   last_word = {host.data_in[31:16], 8'h80, 8'h00};
            2'b11:   last_word = {host.data_in[31:8], 8'h80};
            default: last_word = host.data_in;
        endcase
    end

    assign len_add    = (host.last_in && host.last_bytes_in != 2'b00)
                        ? LEN_WIDTH'({host.last_bytes_in, 3'b000}) : LEN_WIDTH'(32);
    assign marker_pos = {1'b0, idx_q} + ((host.last_bytes_in == 2'b00) ? 5'd1 : 5'd0);

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        exp_d     = exp_q;
        len_d     = len_q;
        marker_d  = marker_q;
        final_d   = final_q;
        msg_end_d = msg_end_q;
        first_d   = first_q;
        fsm_d     = fsm_q;
        cnt_d     = cnt_q;
        data_d    = '0;
        bdone_d   = 1'b0;
        mdone_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (host.start_in) begin
                    state_d   = S_LOAD;
                    idx_d     = 4'd0;
                    exp_d     = 7'd0;
                    len_d     = '0;
                    marker_d  = 1'b0;
                    final_d   = 1'b0;
                    msg_end_d = 1'b0;
                    first_d   = 1'b1;
                    fsm_d     = PH_LOAD;
                    cnt_d     = 7'd0;
                end
            end
            S_LOAD: begin
                fsm_d = PH_LOAD;
                if (accept) begin
                    data_d = host.last_in ? last_word : host.data_in;
                    cnt_d  = 7'(idx_q);
                    len_d  = len_q + len_add;
                    idx_d  = idx_q + 4'd1;
                    if (host.last_in) begin
                        msg_end_d = 1'b1;
                        marker_d  = (host.last_bytes_in == 2'b00);
                        final_d   = (marker_pos <= 5'd13);
                        state_d   = (idx_q == 4'd15) ? S_EXPAND : S_PAD;
                    end else if (idx_q == 4'd15) begin
                        state_d = S_EXPAND;
                    end
                end
            end
            S_PAD: begin
                fsm_d    = PH_LOAD;
                data_d   = pad_word(idx_q, marker_q, final_q, len64);
                cnt_d    = 7'(idx_q);
                marker_d = 1'b0;
                idx_d    = idx_q + 4'd1;
                if (idx_q == 4'd15) state_d = S_EXPAND;
            end
            S_EXPAND: begin
                if (exp_q == 7'd64) begin
                    // Exit cycle: done pulses, and the extra pad block emits word 0 here.
                    bdone_d = 1'b1;
                    first_d = 1'b0;
                    exp_d   = 7'd0;
                    cnt_d   = 7'd0;
                    idx_d   = 4'd0;
                    if (final_q) begin
                        mdone_d = 1'b1;
                        fsm_d   = PH_IDLE;
                        state_d = S_IDLE;
                    end else if (msg_end_q) begin
                        fsm_d    = PH_LOAD;
                        data_d   = pad_word(4'd0, marker_q, 1'b1, len64);
                        marker_d = 1'b0;
                        final_d  = 1'b1;
                        idx_d    = 4'd1;
                        state_d  = S_PAD;
                    end else begin
                        fsm_d   = PH_LOAD;
                        state_d = S_LOAD;
                    end
                end else begin
                    fsm_d = PH_EXPAND;
                    cnt_d = exp_q;
                    exp_d = exp_q + 7'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            exp_q     <= '0;
            len_q     <= '0;
            marker_q  <= 1'b0;
            final_q   <= 1'b0;
            msg_end_q <= 1'b0;
            first_q   <= 1'b0;
            ready_q   <= 1'b0;
            fsm_q     <= PH_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            bdone_q   <= 1'b0;
            mdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            exp_q     <= exp_d;
            len_q     <= len_d;
            marker_q  <= marker_d;
            final_q   <= final_d;
            msg_end_q <= msg_end_d;
            first_q   <= first_d;
            ready_q   <= ready_d;
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            bdone_q   <= bdone_d;
            mdone_q   <= mdone_d;
        end
    end

    assign host.ready_out  = ready_q;
    assign fsm_out         = fsm_q;
    assign count_out       = cnt_q;
    assign data_out        = data_q;
    assign first_block_out = first_q;
    assign block_done_out  = bdone_q;
    assign msg_done_out    = mdone_q;
endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Directed bench for sha256_msg_feeder. Expected 512-bit blocks come from a
// byte-level SHA-256 padding model and are queued when a message is sent; the
// monitor rebuilds each block from the LOAD beats and checks it at EXPAND beat 0.
module tb_sha256_msg_feeder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  fsm_out;
    logic [6:0]  count_out;
    logic [31:0] data_out;
    logic        first_block_out;
    logic        block_done_out;
    logic        msg_done_out;

    always #5 clk = ~clk;

    sha256_msg_feeder_if host_if ();

    sha256_msg_feeder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .host            (host_if),
        .fsm_out         (fsm_out),
        .count_out       (count_out),
        .data_out        (data_out),
        .first_block_out (first_block_out),
        .block_done_out  (block_done_out),
        .msg_done_out    (msg_done_out)
    );

    typedef struct packed {
        logic [511:0] blk;
        logic         first;
        logic         fin;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] msg_w [16];
    logic [31:0] mon_w [16];
    logic [511:0] mon_blk;
    int          mon_beats = 0;
    logic        mon_final = 1'b0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Standard SHA-256 padding done on a byte stream, split into 512-bit blocks.
    task automatic push_model(input int nw, input int lastn);
        logic [7:0]  b[$];
        logic [63:0] bitlen;
        int          k;
        int          nblk;
        exp_t        e;
        for (int i = 0; i < nw; i++) begin
            k = (i == nw - 1) ? lastn : 4;
            for (int j = 0; j < k; j++) b.push_back(msg_w[i][31-8*j -: 8]);
        end
        bitlen = 64'(b.size()) * 64'd8;
        b.push_back(8'h80);
        while ((b.size() % 64) != 56) b.push_back(8'h00);
        for (int j = 0; j < 8; j++) b.push_back(bitlen[63-8*j -: 8]);
        nblk = b.size() / 64;
        for (int bi = 0; bi < nblk; bi++) begin
            for (int j = 0; j < 64; j++) e.blk[511-8*j -: 8] = b[bi*64 + j];
            e.first = (bi == 0);
            e.fin   = (bi == nblk - 1);
            sb_q.push_back(e);
        end
    endtask

    // Expander-side monitor: collects LOAD words, checks blocks and done pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mon_w[i] = 32'h0;
            mon_beats = 0;
            mon_final = 1'b0;
        end else begin
            if (fsm_out == 3'b010 && data_out != 32'h0) mon_w[count_out[3:0]] = data_out;
            if (fsm_out == 3'b011) begin
                check("expand_count", 512'(count_out), 512'(mon_beats));
                check("expand_data", 512'(data_out), 512'(0));
                if (count_out == 7'd0) begin
                    n_checks++;
                    assert (sb_q.size() > 0) else begin
                        n_fail++;
                        $error("FAIL block_unexpected observed=block expected=none");
                    end
                    if (sb_q.size() > 0) begin
                        sb_e = sb_q.pop_front();
                        for (int i = 0; i < 16; i++) mon_blk[511-32*i -: 32] = mon_w[i];
                        check("block_words", mon_blk, sb_e.blk);
                        check("first_block", 512'(first_block_out), 512'(sb_e.first));
                        mon_final = sb_e.fin;
                    end
                    for (int i = 0; i < 16; i++) mon_w[i] = 32'h0;
                end
                mon_beats++;
            end
            if (block_done_out) begin
                check("beats_before_done", 512'(mon_beats), 512'(64));
                check("msg_done", 512'(msg_done_out), 512'(mon_final));
                mon_beats = 0;
            end else begin
                check("msg_done_alone", 512'(msg_done_out), 512'(0));
            end
        end
    end

    // Send one message; inject: 0 none, 1 start_in during EXPAND, 2 reset at EXPAND beat 30.
    task automatic run_msg(input int nw, input int lastn, input int gap_after, input int inject);
        int t;
        int dones;
        push_model(nw, lastn);
        @(negedge clk);
        host_if.start_in = 1'b1;
        @(negedge clk);
        host_if.start_in = 1'b0;
        for (int i = 0; i < nw; i++) begin
            host_if.valid_in      = 1'b1;
            host_if.data_in       = msg_w[i];
            host_if.last_in       = (i == nw - 1);
            host_if.last_bytes_in = 2'(lastn % 4);
            t = 0;
            while (host_if.ready_out !== 1'b1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("ready_wait", 512'(host_if.ready_out), 512'(1));
            @(posedge clk);
            @(negedge clk);
            check("load_index", 512'({fsm_out, count_out}), 512'({3'b010, 7'(i)}));
            if (i == gap_after || i == nw - 1) host_if.valid_in = 1'b0;
            if (i == gap_after) begin
                repeat (5) begin
                    @(negedge clk);
                    check("gap_hold", 512'({fsm_out, count_out, data_out}),
                          512'({3'b010, 7'(i), 32'h0}));
                end
            end
        end
        host_if.last_in = 1'b0;
        t = 0;
        while (msg_done_out !== 1'b1 && t < 400) begin
            if (inject == 1 && fsm_out == 3'b011 && count_out == 7'd10) begin
                host_if.start_in = 1'b1;
                @(negedge clk);
                host_if.start_in = 1'b0;
            end else if (inject == 2 && fsm_out == 3'b011 && count_out == 7'd30) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("reset_outputs", 512'({fsm_out, count_out, data_out, first_block_out,
                      block_done_out, msg_done_out, host_if.ready_out}), 512'(0));
                rst_n = 1'b1;
                dones = 0;
                repeat (100) begin
                    @(negedge clk);
                    if (block_done_out || msg_done_out) dones++;
                end
                check("no_done_after_abort", 512'(dones), 512'(0));
                check("idle_after_abort", 512'(fsm_out), 512'(0));
                return;
            end else begin
                @(negedge clk);
            end
            t++;
        end
        check("msg_done_seen", 512'(msg_done_out), 512'(1));
        check("idle_at_done", 512'({fsm_out, block_done_out}), 512'({3'b000, 1'b1}));
        repeat (3) @(negedge clk);
        check("idle_after_msg", 512'({fsm_out, host_if.ready_out}), 512'(0));
    endtask

    initial begin
        host_if.start_in      = 1'b0;
        host_if.data_in       = 32'h0;
        host_if.valid_in      = 1'b0;
        host_if.last_in       = 1'b0;
        host_if.last_bytes_in = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_state", 512'({fsm_out, count_out, data_out, first_block_out,
              block_done_out, msg_done_out, host_if.ready_out}), 512'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // valid_in with no start is ignored
        host_if.valid_in = 1'b1;
        repeat (3) @(negedge clk);
        host_if.valid_in = 1'b0;
        check("no_start_ignored", 512'({fsm_out, host_if.ready_out}), 512'(0));

        // "abc"
        msg_w[0] = 32'h6162_6300;
        run_msg(1, 3, -1, 0);

        // 14 full words: marker at 14, length in an extra block
        for (int i = 0; i < 16; i++) msg_w[i] = $urandom();
        run_msg(14, 4, -1, 0);

        // 16 full words: marker opens the extra block
        for (int i = 0; i < 16; i++) msg_w[i] = $urandom();
        run_msg(16, 4, -1, 0);

        // Partial last word at 14 and at 15
        for (int i = 0; i < 16; i++) msg_w[i] = $urandom();
        run_msg(15, 3, -1, 0);
        for (int i = 0; i < 16; i++) msg_w[i] = $urandom();
        run_msg(16, 2, -1, 0);

        // valid_in gap after word 6
        for (int i = 0; i < 16; i++) msg_w[i] = $urandom();
        run_msg(10, 1, 6, 0);

        // Reset at EXPAND beat 30, then restart
        msg_w[0] = 32'h6162_6300;
        run_msg(1, 3, -1, 2);
        run_msg(1, 3, -1, 0);

        // start_in during EXPAND is ignored
        for (int i = 0; i < 16; i++) msg_w[i] = $urandom();
        run_msg(3, 2, -1, 1);

        check("scoreboard_empty", 512'(sb_q.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
